simmem_release_scheduler: RTL and testbench
===========================================

# simmem_release_scheduler

Delay scheduler that drives the per-ID release enables of the simmem read-data and write-response message banks. Each accepted entry carries a bank select (read data or write response), an AXI ID and a delay in cycles. The entry waits in a slot array while its delay counts down, then raises the release enable for its bank/ID. The slot is freed when the message bank reports that it has released a message for that bank/ID.

## Interface

Parameters:
- NumSlots, 16: number of concurrently tracked entries, ≥2.
- IDWidth, 4: AXI ID width. Release vectors are 2**IDWidth wide.
- DelayWidth, 8: width of the per-entry delay field.

Ports:
- clk_i  in  1: sole clock. All state updates on its rising edge.
- rst_i  in  1: one clock; reset is synchronous and active-high.
- in_valid_i  in  1: new entry offered.
- in_ready_o  out  1: a free slot exists.
- in_bank_i  in  1: 0 = read data (bank index 0), 1 = write response (bank index 1).
- in_id_i  in  IDWidth: AXI ID of the entry.
- in_delay_i  in  DelayWidth: cycles to wait before release.
- release_en_o  out  [1:0][2**IDWidth-1:0]: bit [b][id] is high while at least one expired slot exists for bank b / ID id. Drives the message-bank release_en input directly.
- released_valid_i  in  [1:0]: per bank, the message bank released one message this cycle.
- released_id_i  in  [1:0][IDWidth-1:0]: per bank, the ID of that message.
- occupancy_o  out  $clog2(NumSlots+1): number of valid slots.
- error_o  out  1: sticky flag, set on an unmatched release acknowledgement.

## Operation

- Slot state: valid, bank, id, counter[DelayWidth-1:0].
- Reset: all slots invalid. Output reset values:
  - in_ready_o=1
  - release_en_o=0
  - occupancy_o=0
  - error_o=0
- Allocation:
  - On in_valid_i && in_ready_o, the lowest-index invalid slot becomes valid with bank, id, and counter=in_delay_i.
  - in_ready_o = OR of invalid slots, computed from registered state only.
  - A slot freed in cycle t is not offered for allocation until t+1.
- Countdown: every valid slot with counter>0 decrements by 1 each cycle. The counter saturates at 0 and never wraps.
- Expired: a slot is expired when it is valid and counter==0.
  - release_en_o[b][id] = OR over expired slots with matching bank and id. This is combinational from registered slot state.
- Release acknowledgement, evaluated per bank independently:
  - When released_valid_i[b] is high, the lowest-index expired slot with bank b and id released_id_i[b] is invalidated.
  - Only slots that are expired in the current registered state are eligible.
  - If no slot matches, there is no state change and error_o is set. error_o clears only on reset.
- Simultaneous events:
  - Both banks may acknowledge in the same cycle. Their slots are disjoint by bank, so both frees occur.
  - An allocation and one or two frees may occur in the same cycle.
  - occupancy_o next value = occupancy + accept − number of frees.
- Ordering: the block counts eligible releases per bank/ID only. Per-ID response ordering is guaranteed by the message bank.
- Delay 0: the entry is expired in the cycle after acceptance.

## Timing

- Latency: an entry accepted at edge t with delay d sees counter=d at cycle t+1. release_en_o for its bank/ID goes high at cycle t+1+d.
- release_en_o drops in the cycle after the acknowledging edge, unless another expired slot with the same bank/ID remains.
- in_ready_o and occupancy_o reflect state after the most recent edge. There is no combinational path from in_valid_i to in_ready_o.
- Full condition: occupancy_o==NumSlots implies in_ready_o=0. An offered entry is then held by the upstream (valid/ready rule: in_valid_i and payload remain stable until accepted).
- Reset asserted mid-operation: at the next edge all slots are cleared and outputs take their reset values, regardless of other inputs that cycle. Acknowledgements during reset are ignored and do not set error_o.

## Test plan

- Single entry: bank 0, ID 3, delay 5 accepted at cycle 10 -> release_en_o[0][3] rises at cycle 16. Acknowledge (bank 0, ID 3) at cycle 18 -> release_en_o[0][3]=0 at cycle 19, occupancy_o back to 0.
- Delay 0 and counter saturation: accept bank 1, ID 0, delay 0 -> release_en_o[1][0] high the next cycle. Hold it unacknowledged for 300 cycles -> stays high, no wrap.
- Fill/drain: issue 16 entries, delay 2, IDs 0..15 alternating banks -> in_ready_o=0 after the 16th and occupancy_o=16. A 17th offer is held. Freeing one slot lets the held entry be accepted the following cycle.
- Duplicate ID: two entries bank 0 ID 7 with delays 1 and 4. A single acknowledgement after both expire -> release_en_o[0][7] stays high. A second acknowledgement -> low.
- Simultaneous: in one cycle, acknowledge bank 0 ID 1, acknowledge bank 1 ID 2, and accept a new entry -> two slots freed, one allocated into the lowest free slot that existed before the edge, occupancy_o decreases by 1.
- Error and reset: acknowledge bank 1 ID 5 with no expired match -> error_o=1, occupancy unchanged. Assert rst_i with 4 slots valid -> next cycle error_o=0, occupancy_o=0, release_en_o=0.

Source files
------------

// File: rtl/simmem_release_scheduler.sv
// Delay scheduler for the simmem message banks: holds (bank, id, delay) entries,
// counts each down and raises the per-bank/per-ID release enable once it expires.
module simmem_release_scheduler #(
    parameter int NumSlots   = 16,
    parameter int IDWidth    = 4,
    parameter int DelayWidth = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic                               in_bank_i,
    input  logic [IDWidth-1:0]                 in_id_i,
    input  logic [DelayWidth-1:0]              in_delay_i,
    output logic [1:0][(2**IDWidth)-1:0]       release_en_o,
    input  logic [1:0]                         released_valid_i,
    input  logic [1:0][IDWidth-1:0]            released_id_i,
    output logic [$clog2(NumSlots+1)-1:0]      occupancy_o,
    output logic                               error_o
);
    localparam int OccWidth     = $clog2(NumSlots + 1);
    localparam int SlotIdxWidth = $clog2(NumSlots);
    localparam logic [DelayWidth-1:0] CntOne = DelayWidth'(1);

    logic [NumSlots-1:0]                 valid_q, valid_d;
    logic [NumSlots-1:0]                 bank_q, bank_d;
    logic [NumSlots-1:0][IDWidth-1:0]    id_q, id_d;
    logic [NumSlots-1:0][DelayWidth-1:0] cnt_q, cnt_d;
    logic [OccWidth-1:0]                 occ_q, occ_d;
    logic                                error_q, error_d;

    logic [NumSlots-1:0]                 expired;
    logic                                accept;
    logic [SlotIdxWidth-1:0]             alloc_idx;
    logic [1:0]                          free_hit;
    logic [1:0][SlotIdxWidth-1:0]        free_idx;
    logic [1:0]                          free_cnt;

    always_comb begin
        expired      = '0;
        release_en_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            expired[i] = valid_q[i] && (cnt_q[i] == '0);
            if (expired[i]) release_en_o[bank_q[i]][id_q[i]] = 1'b1;
        end
    end

    // Valid/ready: an entry transfers on a rising edge where in_valid_i and
    // in_ready_o are both high; upstream holds valid and payload until then.
    // Ready depends only on registered slot state, so a slot freed this cycle
    // becomes allocatable on the next one.
    assign in_ready_o = |(~valid_q);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        alloc_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = SlotIdxWidth'(i);
        end
    end

    // Per-bank acknowledgement match: lowest-index expired slot wins.
    always_comb begin
        free_hit = '0;
        free_idx = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = NumSlots - 1; i >= 0; i--) begin
                if (released_valid_i[b] && expired[i] && (bank_q[i] == 1'(b)) &&
                    (id_q[i] == released_id_i[b])) begin
                    free_hit[b] = 1'b1;
                    free_idx[b] = SlotIdxWidth'(i);
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        bank_d  = bank_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NumSlots; i++) begin
            if (valid_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - CntOne;
        end
        // Freed slots were valid and the allocated slot was not, so they never collide.
        for (int b = 0; b < 2; b++) begin
            if (free_hit[b]) valid_d[free_idx[b]] = 1'b0;
        end
        if (accept) begin
            valid_d[alloc_idx] = 1'b1;
            bank_d[alloc_idx]  = in_bank_i;
            id_d[alloc_idx]    = in_id_i;
            cnt_d[alloc_idx]   = in_delay_i;
        end
        free_cnt = 2'(free_hit[0]) + 2'(free_hit[1]);
        occ_d    = occ_q + OccWidth'(accept) - OccWidth'(free_cnt);
        error_d  = error_q
                 | (released_valid_i[0] & ~free_hit[0])
                 | (released_valid_i[1] & ~free_hit[1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            bank_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
            error_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            bank_q  <= bank_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            error_q <= error_d;
        end
    end

    assign occupancy_o = occ_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler: hand-computed expectations for
// latency, saturation, fill/drain, duplicate IDs, simultaneous events, error and reset.
module tb_simmem_release_scheduler;
    localparam int NumSlots   = 16;
    localparam int IDWidth    = 4;
    localparam int DelayWidth = 8;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_bank;
    logic [IDWidth-1:0]            in_id;
    logic [DelayWidth-1:0]         in_delay;
    logic [1:0][15:0]              rel;
    logic [1:0]                    rel_valid;
    logic [1:0][IDWidth-1:0]       rel_id;
    logic [4:0]                    occ;
    logic                          err;

    int err_cnt = 0;
    int chk_cnt = 0;

    simmem_release_scheduler #(
        .NumSlots  (NumSlots),
        .IDWidth   (IDWidth),
        .DelayWidth(DelayWidth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_bank_i       (in_bank),
        .in_id_i         (in_id),
        .in_delay_i      (in_delay),
        .release_en_o    (rel),
        .released_valid_i(rel_valid),
        .released_id_i   (rel_id),
        .occupancy_o     (occ),
        .error_o         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_bank   = 1'b0;
        in_id     = '0;
        in_delay  = '0;
        rel_valid = '0;
        rel_id    = '0;
    endtask

    task automatic offer(input logic bank, input int id, input int delay);
        in_valid = 1'b1;
        in_bank  = bank;
        in_id    = IDWidth'(id);
        in_delay = DelayWidth'(delay);
    endtask

    task automatic ack(input int bank, input int id);
        rel_valid[bank] = 1'b1;
        rel_id[bank]    = IDWidth'(id);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_rel", 32'(rel), 32'd0);
        check("reset_occ", 32'(occ), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Single entry: delay 5 -> enable rises five edges after the accept edge
        offer(1'b0, 3, 5);
        tick(1);
        idle();
        check("single_occ", 32'(occ), 32'd1);
        tick(4);
        check("single_before", 32'(rel[0][3]), 32'd0);
        tick(1);
        check("single_rise", 32'(rel[0][3]), 32'd1);
        tick(2);
        check("single_hold", 32'(rel[0][3]), 32'd1);
        ack(0, 3);
        tick(1);
        idle();
        check("single_drop", 32'(rel[0][3]), 32'd0);
        check("single_occ0", 32'(occ), 32'd0);
        check("single_err", 32'(err), 32'd0);

        // Delay 0 and saturation
        offer(1'b1, 0, 0);
        tick(1);
        idle();
        check("d0_rise", 32'(rel[1][0]), 32'd1);
        tick(300);
        check("d0_sat", 32'(rel[1][0]), 32'd1);
        check("d0_vec", 32'(rel), 32'h0001_0000);
        ack(1, 0);
        tick(1);
        idle();
        check("d0_drop", 32'(rel), 32'd0);
        check("d0_occ", 32'(occ), 32'd0);

        // Fill/drain
        for (int i = 0; i < 16; i++) begin
            offer(1'(i % 2), i, 2);
            tick(1);
        end
        offer(1'b0, 9, 3);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_occ", 32'(occ), 32'd16);
        tick(2);
        check("held_occ", 32'(occ), 32'd16);
        check("full_rel", 32'(rel), 32'hAAAA_5555);
        ack(0, 0);
        tick(1);
        rel_valid = '0;
        check("free_occ", 32'(occ), 32'd15);
        check("free_ready", 32'(in_ready), 32'd1);
        check("free_rel0", 32'(rel[0]), 32'h5554);
        tick(1);
        idle();
        check("held_accept_occ", 32'(occ), 32'd16);
        check("held_accept_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i < 16; i++) begin
            ack(i % 2, i);
            tick(1);
            idle();
        end
        check("drain_rel", 32'(rel), 32'h0000_0200);
        ack(0, 9);
        tick(1);
        idle();
        check("drain_occ", 32'(occ), 32'd0);
        check("drain_err", 32'(err), 32'd0);

        // Duplicate ID
        offer(1'b0, 7, 1);
        tick(1);
        offer(1'b0, 7, 4);
        tick(1);
        idle();
        check("dup_first", 32'(rel[0][7]), 32'd1);
        tick(4);
        ack(0, 7);
        tick(1);
        idle();
        check("dup_one_ack", 32'(rel[0][7]), 32'd1);
        check("dup_occ1", 32'(occ), 32'd1);
        ack(0, 7);
        tick(1);
        idle();
        check("dup_two_ack", 32'(rel[0][7]), 32'd0);
        check("dup_occ0", 32'(occ), 32'd0);

        // Simultaneous: two frees and one accept in the same cycle
        offer(1'b0, 1, 0);
        tick(1);
        offer(1'b1, 2, 0);
        tick(1);
        offer(1'b0, 4, 20);
        tick(1);
        idle();
        check("sim_pre_occ", 32'(occ), 32'd3);
        check("sim_pre_rel", 32'(rel), 32'h0004_0002);
        ack(0, 1);
        ack(1, 2);
        offer(1'b1, 6, 10);
        tick(1);
        idle();
        check("sim_occ", 32'(occ), 32'd2);
        check("sim_rel", 32'(rel), 32'd0);
        check("sim_err", 32'(err), 32'd0);

        // Error: no match on bank 1, and a valid but unexpired match on bank 0
        ack(1, 5);
        ack(0, 4);
        tick(1);
        idle();
        check("err_set", 32'(err), 32'd1);
        check("err_occ", 32'(occ), 32'd2);
        tick(8);
        check("sim_new_before", 32'(rel[1][6]), 32'd0);
        tick(1);
        check("sim_new_rise", 32'(rel[1][6]), 32'd1);
        check("err_sticky", 32'(err), 32'd1);

        // Reset with four slots valid and an acknowledgement pending
        offer(1'b0, 12, 50);
        tick(1);
        offer(1'b1, 13, 50);
        tick(1);
        idle();
        check("pre_rst_occ", 32'(occ), 32'd4);
        rst = 1'b1;
        ack(1, 5);
        offer(1'b0, 3, 1);
        tick(1);
        idle();
        rst = 1'b0;
        check("rst_err", 32'(err), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_rel", 32'(rel), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        tick(2);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_occ", 32'(occ), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
